histogram_builder: RTL
======================

# histogram_builder

Builds the 256-bin luminance histogram of one frame into the dual-port histogram RAM, where `CumulativeHistogram` later reads it. It is the writer for that RAM.

- On `iStart` it zeroes all 256 bins.
- It then accepts one 8-bit pixel per cycle and increments the matching bin with a pipelined read-modify-write.
- It pulses `oDone` once the last increment has been written.
- It sits between the camera pixel stream (grey-scale conversion output) and the histogram RAM. It uses RAM port A for reads and port B for writes. The RAM is the single-clock true dual-port type with a 1-cycle registered read.

## Interface
Parameters:
- `BINS`, 256: number of bins. It is fixed by the 8-bit pixel and is not to be overridden.
- `CW`, 20: bin and pixel-count width. It covers 640×480 = 307200.

Ports:
- `iClk` in 1: the single clock; all logic is on its rising edge.
- `iRst_n` in 1: asynchronous active-low reset.
- `iStart` in 1: one-cycle pulse that begins a frame. Sampled only in IDLE.
- `iPixel` in 8: pixel value, which is the bin index.
- `iValid` in 1: `iPixel` is valid this cycle.
- `iFrameEnd` in 1: the last pixel of the frame. It may coincide with `iValid`.
- `oReady` in the out direction, 1: high only in ACCUM. Pixels offered while it is low are dropped.
- `oBusy` out 1: high in CLEAR, ACCUM and FLUSH.
- `oAddrRdHist` out 8: RAM port A read address.
- `iQHist` in CW: RAM port A read data, valid 1 cycle after the address.
- `oAddrWrHist` out 8: RAM port B write address.
- `oDataWrHist` out CW: RAM port B write data.
- `oWE` out 1: RAM port B write enable.
- `oPixelCount` out CW: pixels accepted this frame. Saturates at 2^CW−1.
- `oDone` out 1: one-cycle pulse when the histogram is complete.

## Operation
States:
- **IDLE**: `iStart` → CLEAR. All other inputs are ignored.
- **CLEAR**: clear counter c = 0..255. Each cycle drives `oWE`=1, `oAddrWrHist`=c, `oDataWrHist`=0. After c = 255 → ACCUM. `oPixelCount` is cleared on entry.
- **ACCUM** (pipeline stage 0): an accepted pixel is `iValid`&`oReady`.
  - It drives `oAddrRdHist`=`iPixel` combinationally.
  - It registers the pixel into stage 1 (p1, v1).
  - It increments `oPixelCount`.
  - Accepted `iFrameEnd` → FLUSH.
- **Stage 1** (runs in ACCUM and FLUSH): if v1, old = fwd ? lastData : `iQHist`.
  - Write `oAddrWrHist`=p1, `oDataWrHist`=sat(old+1), `oWE`=1.
  - Register lastAddr=p1, lastData=the written value, lastV=1.
- **Forwarding**: fwd = lastV & (lastAddr == p1).
  - It covers a read issued in the same cycle as the write to that bin. The RAM returns old data on a mixed-port read-during-write.
  - One forwarding entry is sufficient; the bench must prove it.
- **FLUSH**: one cycle, in which stage 1 writes the final pixel → DONE.
- **DONE**: `oDone`=1 for one cycle → IDLE.
- **Arithmetic**: sat(x+1) = (x == 2^CW−1) ? x : x+1.

Boundary conditions:
- `iStart` outside IDLE is ignored.
- `iValid` in CLEAR/FLUSH/DONE: the pixel is dropped and not counted.
- `iFrameEnd` without `iValid` in ACCUM → FLUSH, with no extra count.
- Back-to-back identical pixels are counted exactly, at any run length.
- Reset mid-operation forces IDLE, `oWE`=0, pipeline invalid. RAM contents are undefined until the next CLEAR.

## Timing
- **Reset values**: all outputs are 0, including `oReady`, `oBusy`, `oWE`, `oDone`, `oPixelCount`, and all addresses and data. lastV=0, v1=0.
- **Clear phase**: `iStart` sampled at cycle t. CLEAR occupies t+1..t+256. `oReady` rises at t+257.
- **Pixel latency**: a pixel accepted at cycle k is written at cycle k+1.
- **Throughput**: 1 pixel per cycle with no stalls.
- **Frame end**: `iFrameEnd` at cycle f. Last write at f+1 (FLUSH). `oDone` at f+2. `oBusy` falls at f+2.
- The next `iStart` is accepted from f+3.
- `oDone` and all RAM outputs are registered, except `oAddrRdHist`, which is combinational from `iPixel`.

## Test plan
- **Clear**: preload RAM with 0xABCDE everywhere, pulse `iStart`, then end the frame with no pixels. Required: all 256 bins read 0, `oPixelCount`=0, `oDone` at exactly start+257+2.
- **Runs**: 5 back-to-back pixels of 7, then 3 of 200, frame end on the last. Required: bin7=5, bin200=3, others 0, `oPixelCount`=8.
- **Interleaved**: pattern A,B,A,A,B,A with A=3, B=4, including idle gaps of 0 and 1 cycle. Required: bin3=4, bin4=2.
- **Ramp**: a full 640×480 frame of `iPixel`=(x+y)%256. Required: bins match a software histogram; `oPixelCount`=307200.
- **Drops and reset**: pixels offered during CLEAR are not counted. `iRst_n` pulsed low mid-ACCUM → `oWE`/`oBusy`/`oReady`=0 immediately. A new frame then counts correctly.
- **Saturation**: 2^20+4 pixels of value 0. Required: bin0=0xFFFFF and `oPixelCount`=0xFFFFF.

Source files
------------

// File: rtl/histogram_builder.sv
// histogram_builder: builds the 256-bin luminance histogram of one frame in an
// external true dual-port RAM (port A read, port B write, 1-cycle registered
// read that returns old data on a mixed-port read-during-write).
// Flow: IDLE -> CLEAR (256 zero writes) -> ACCUM (1 px/cycle RMW) -> FLUSH -> DONE.
module histogram_builder #(
    parameter int BINS = 256,
    parameter int CW   = 20
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iStart,
    input  logic [7:0]    iPixel,
    input  logic          iValid,
    input  logic          iFrameEnd,
    output logic          oReady,
    output logic          oBusy,
    output logic [7:0]    oAddrRdHist,
    input  logic [CW-1:0] iQHist,
    output logic [7:0]    oAddrWrHist,
    output logic [CW-1:0] oDataWrHist,
    output logic          oWE,
    output logic [CW-1:0] oPixelCount,
    output logic          oDone
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CW-1:0] CMAX     = {CW{1'b1}};
    localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [7:0]    LAST_BIN = 8'(BINS - 1);

    logic [2:0]    state_q, state_d;
    logic [7:0]    clr_q, clr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    // stage 1 of the read-modify-write pipeline
    logic [7:0]    p1_q, p1_d;
    logic          v1_q, v1_d;
    // single forwarding entry: the bin written in the previous cycle
    logic [7:0]    last_addr_q, last_addr_d;
    logic [CW-1:0] last_data_q, last_data_d;
    logic          last_v_q, last_v_d;

    logic          accept;
    logic          fwd;
    logic [CW-1:0] old_val;
    logic [CW-1:0] inc_val;

    assign accept  = (state_q == S_ACCUM) && iValid;
    // The read for p1 was issued while the previous write to the same bin was
    // in flight; the RAM returned the pre-write value, so use our own copy.
    assign fwd     = last_v_q && (last_addr_q == p1_q);
    assign old_val = fwd ? last_data_q : iQHist;
    assign inc_val = (old_val == CMAX) ? old_val : old_val + ONE;

    // Next-state: control FSM, clear counter, pixel counter and pipeline
    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        p1_d        = p1_q;
        v1_d        = accept;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        last_v_d    = v1_q;

        if (accept) p1_d = iPixel;
        if (v1_q) begin
            last_addr_d = p1_q;
            last_data_d = inc_val;
        end

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d = S_CLEAR;
                    clr_d   = 8'd0;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                clr_d = clr_q + 8'd1;
                if (clr_q == LAST_BIN) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (accept && (cnt_q != CMAX)) cnt_d = cnt_q + ONE;
                if (iFrameEnd) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset leaves the pipeline empty and the FSM idle
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= S_IDLE;
            clr_q       <= 8'd0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            p1_q        <= 8'd0;
            v1_q        <= 1'b0;
            last_addr_q <= 8'd0;
            last_data_q <= '0;
            last_v_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            p1_q        <= p1_d;
            v1_q        <= v1_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            last_v_q    <= last_v_d;
        end
    end

    // Write port is decoded from registered state plus the RAM's own output
    // register, so a pixel accepted at cycle k lands in the RAM at cycle k+1.
    always_comb begin
        oWE         = 1'b0;
        oAddrWrHist = 8'd0;
        oDataWrHist = '0;
        if (state_q == S_CLEAR) begin
            oWE         = 1'b1;
            oAddrWrHist = clr_q;
        end else if (v1_q) begin
            oWE         = 1'b1;
            oAddrWrHist = p1_q;
            oDataWrHist = inc_val;
        end
    end

    assign oReady      = (state_q == S_ACCUM);
    assign oBusy       = (state_q == S_CLEAR) || (state_q == S_ACCUM) || (state_q == S_FLUSH);
    assign oAddrRdHist = (state_q == S_ACCUM) ? iPixel : 8'd0;
    assign oPixelCount = cnt_q;
    assign oDone       = done_q;

endmodule
